sample_change_detector: RTL and testbench
=========================================

// Module: sample_change_detector
// PURPOSE
//   Downstream consumer of the Previous-tracked input sample. Compares each accepted sample
//   with the previously accepted one, raises a change event on a difference, and queues
//   events (value, delta, timestamp) in a small FIFO with a valid/ready output.
//   Sits between the sampled input bus and the event/logging consumer.
// PARAMETERS
//   WIDTH     16  sample width in bits
//   DEPTH     4   event FIFO depth; power of 2, >= 2
//   TS_WIDTH  16  timestamp counter width
// PORTS
//   clk            in   1         single clock, rising edge
//   reset          in   1         synchronous, active-high
//   sample_in      in   WIDTH     input sample
//   sample_valid   in   1         sample_in is accepted this cycle
//   evt_valid      out  1         event at FIFO head
//   evt_ready      in   1         consumer takes head event
//   evt_value      out  WIDTH     new sample value
//   evt_delta      out  WIDTH     new - baseline, modulo 2^WIDTH
//   evt_timestamp  out  TS_WIDTH  timestamp of the sample that caused the event
//   drop_count     out  8         events lost to a full FIFO; saturates at 255
//   primed         out  1         baseline sample captured
// BEHAVIOUR
//   - Reset: all outputs 0; FIFO emptied; baseline 0; primed 0; timestamp 0; FSM UNPRIMED.
//     Reset mid-operation discards all queued and pending events.
//   - Timestamp: free-running; +1 every clk; wraps to 0. Event stamp = counter value in the
//     cycle its sample is accepted.
//   - FSM UNPRIMED: first sample_valid -> baseline=sample_in, primed=1, ARMED; no event.
//   - FSM ARMED: sample_valid && sample_in != baseline -> push event; baseline=sample_in.
//     Equal sample -> no event.
//   - Latency: evt_valid rises the cycle after the changing sample when the FIFO is empty.
//   - Delta: unsigned subtraction truncated to WIDTH (0x0001 -> 0xFFFF gives 0xFFFE).
//   - Handshake: pop on evt_valid && evt_ready. evt_* held stable while
//     evt_valid && !evt_ready. evt_valid = FIFO not empty.
//   - Full, push and no pop: new event dropped; drop_count += 1, saturating at 255.
//     Full, push and pop in the same cycle: both occur; no drop.
//     Empty, push and pop in the same cycle: pop ignored; the event is queued.
//   - FIFO order strictly first-in first-out. Pointers wrap modulo DEPTH.
// CONFIGURATION
//   STABLE_FILTER_EN defined: glitch filter; adds FSM state PENDING.
//     ARMED:   differing sample -> candidate=sample_in, cand_ts=stamp, PENDING; no push.
//     PENDING: sample == candidate -> push {candidate, candidate-baseline, cand_ts};
//                baseline=candidate; ARMED.
//              sample == baseline -> ARMED; no event.
//              other value -> new candidate and cand_ts; stay PENDING.
//              no sample_valid -> hold.
//   Not defined: no PENDING state; events reported immediately as above.
// STRUCTURE
//   Package sample_change_pkg:
//     - event struct typedef {value, delta, timestamp}
//     - FSM state enum {UNPRIMED, ARMED, PENDING}
//     - DROP_MAX = 8'hFF
//   Sub-module sync_fifo (parameterised width/depth, registered head). Detector FSM, baseline,
//   timestamp and drop counter stay in the top module.
// TESTING
//   1. reset; samples 0x0005, 0x0005, 0x0009; evt_ready=1
//      -> one event {0x0009, delta 0x0004}; evt_valid the cycle after the 3rd sample.
//   2. samples 0x0001, 0xFFFF -> evt_delta=0xFFFE; first sample gives no event; primed=1.
//   3. evt_ready=0; 7 samples, 6 changes; DEPTH=4 -> 4 queued, drop_count=2.
//      Then evt_ready=1 -> drains in arrival order; timestamps monotonic.
//   4. FIFO full; new change in the same cycle as evt_ready=1 -> no drop; count stays 4.
//   5. With STABLE_FILTER_EN: 5,9,5 -> no event; 5,9,9 -> one event {9, delta 4, ts of the
//      first 9}. Without it: 5,9,5 -> two events (delta 4, then 0xFFFC).
//   6. Assert reset with 3 events queued -> evt_valid=0, drop_count=0, primed=0 next cycle;
//      next sample gives no event.

Source files
------------

// File: rtl/sample_change_pkg.sv
// Shared types for the sample change detector: event record, detector FSM states,
// drop-counter limit and its saturating increment.
package sample_change_pkg;

    localparam int         DEF_WIDTH    = 16;
    localparam int         DEF_TS_WIDTH = 16;
    localparam logic [7:0] DROP_MAX     = 8'hFF;

    typedef enum logic [1:0] {
        UNPRIMED = 2'd0,
        ARMED    = 2'd1,
        PENDING  = 2'd2
    } det_state_t;

    // Event record at the default widths; the top builds the same layout at its own widths.
    typedef struct packed {
        logic [DEF_WIDTH-1:0]    value;
        logic [DEF_WIDTH-1:0]    delta;
        logic [DEF_TS_WIDTH-1:0] timestamp;
    } evt_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
        return (cnt == DROP_MAX) ? cnt : cnt + 8'd1;
    endfunction

endpackage

// File: rtl/sample_change_detector_fifo.sv
// Synchronous FIFO with a registered head word. Pop on empty is ignored, and a push
// while full is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             not_empty,
    output logic             full
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr, rd_next;
    logic [PW:0]      count, count_next;
    logic [WIDTH-1:0] head_q, head_next;
    logic             do_push, do_pop;

    assign not_empty = (count != '0);
    assign full      = (count == (PW+1)'(DEPTH));
    assign do_pop    = pop && not_empty;
    assign do_push   = push && (!full || do_pop);
    assign head      = head_q;

    // Head is recomputed from the post-update contents so it is a plain register at the output.
    always_comb begin
        rd_next    = do_pop ? rd_ptr + PW'(1) : rd_ptr;
        count_next = count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        if (count_next == '0) begin
            head_next = '0;
        end else if (do_push && (wr_ptr == rd_next)) begin
            head_next = push_data;
        end else begin
            head_next = mem[rd_next];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            rd_ptr <= rd_next;
            count  <= count_next;
            head_q <= head_next;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/sample_change_detector.sv
// Change detector: compares accepted samples against a baseline and queues change events.
// Optional glitch filter (PENDING state) enabled with `define STABLE_FILTER_EN.
module sample_change_detector
    import sample_change_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = 4,
    parameter int TS_WIDTH = DEF_TS_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WIDTH-1:0]    sample_in,
    input  logic                sample_valid,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [WIDTH-1:0]    evt_value,
    output logic [WIDTH-1:0]    evt_delta,
    output logic [TS_WIDTH-1:0] evt_timestamp,
    output logic [7:0]          drop_count,
    output logic                primed
);
    typedef struct packed {
        logic [WIDTH-1:0]    value;
        logic [WIDTH-1:0]    delta;
        logic [TS_WIDTH-1:0] timestamp;
    } evt_rec_t;

    det_state_t          state, state_d;
    logic [WIDTH-1:0]    baseline, baseline_d;
    logic [TS_WIDTH-1:0] ts;
    logic [7:0]          drops;
    logic                push, fifo_full, fifo_not_empty, drop;
    evt_rec_t            push_evt, head_evt;
    logic                differs;

`ifdef STABLE_FILTER_EN
    logic [WIDTH-1:0]    cand, cand_d;
    logic [TS_WIDTH-1:0] cand_ts, cand_ts_d;
`endif

    assign differs = sample_valid && (sample_in != baseline);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= UNPRIMED;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            UNPRIMED: if (sample_valid) state_d = ARMED;
`ifdef STABLE_FILTER_EN
            ARMED:    if (differs) state_d = PENDING;
            PENDING:  if (sample_valid && (sample_in == cand || sample_in == baseline)) state_d = ARMED;
`endif
            default:  state_d = ARMED;
        endcase
    end

    always_comb begin
        push       = 1'b0;
        push_evt   = '{value: sample_in, delta: sample_in - baseline, timestamp: ts};
        baseline_d = baseline;
`ifdef STABLE_FILTER_EN
        cand_d     = cand;
        cand_ts_d  = cand_ts;
`endif
        case (state)
            UNPRIMED: if (sample_valid) baseline_d = sample_in;
`ifdef STABLE_FILTER_EN
            ARMED: begin
                if (differs) begin
                    cand_d    = sample_in;
                    cand_ts_d = ts;
                end
            end
            PENDING: begin
                // A repeat of the candidate confirms it; the event carries the first sighting's stamp.
                if (sample_valid && sample_in == cand) begin
                    push       = 1'b1;
                    push_evt   = '{value: cand, delta: cand - baseline, timestamp: cand_ts};
                    baseline_d = cand;
                end else if (differs) begin
                    cand_d    = sample_in;
                    cand_ts_d = ts;
                end
            end
`else
            ARMED: begin
                if (differs) begin
                    push       = 1'b1;
                    baseline_d = sample_in;
                end
            end
`endif
            default: ;
        endcase
    end

    // The baseline follows every change, including ones dropped at a full FIFO.
    assign drop = push && fifo_full && !evt_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            baseline <= '0;
            ts       <= '0;
            drops    <= '0;
`ifdef STABLE_FILTER_EN
            cand     <= '0;
            cand_ts  <= '0;
`endif
        end else begin
            baseline <= baseline_d;
            ts       <= ts + TS_WIDTH'(1);
            if (drop) begin
                drops <= sat_inc(drops);
            end
`ifdef STABLE_FILTER_EN
            cand     <= cand_d;
            cand_ts  <= cand_ts_d;
`endif
        end
    end

    sync_fifo #(
        .WIDTH ($bits(evt_rec_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_evt),
        .pop       (evt_ready),
        .head      (head_evt),
        .not_empty (fifo_not_empty),
        .full      (fifo_full)
    );

    assign evt_valid     = fifo_not_empty;
    assign evt_value     = head_evt.value;
    assign evt_delta     = head_evt.delta;
    assign evt_timestamp = head_evt.timestamp;
    assign drop_count    = drops;
    assign primed        = (state != UNPRIMED);

endmodule

// File: tb/tb_sample_change_detector.sv
// Directed self-checking bench for sample_change_detector (handles STABLE_FILTER_EN builds).
module tb_sample_change_detector;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        evt_valid;
    logic        evt_ready;
    logic [15:0] evt_value;
    logic [15:0] evt_delta;
    logic [15:0] evt_timestamp;
    logic [7:0]  drop_count;
    logic        primed;

    logic [15:0] tb_ts;
    logic [47:0] exp_q[$];
    int          checks   = 0;
    int          failures = 0;

    sample_change_detector #(
        .WIDTH    (16),
        .DEPTH    (4),
        .TS_WIDTH (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_in     (sample_in),
        .sample_valid  (sample_valid),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .evt_value     (evt_value),
        .evt_delta     (evt_delta),
        .evt_timestamp (evt_timestamp),
        .drop_count    (drop_count),
        .primed        (primed)
    );

    always #5 clk = ~clk;

    // Reference timestamp: free-running cycle count cleared by reset.
    always @(posedge clk) begin
        if (reset) tb_ts <= 16'h0000;
        else       tb_ts <= tb_ts + 16'h0001;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset        = 1'b1;
        sample_valid = 1'b0;
        evt_ready    = 1'b0;
        sample_in    = 16'h0000;
        step();
        step();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic drive(input logic [15:0] v, input logic rdy);
        sample_in    = v;
        sample_valid = 1'b1;
        evt_ready    = rdy;
        step();
        sample_valid = 1'b0;
        evt_ready    = 1'b0;
    endtask

    // One settled sample: under the filter it is presented twice so it is confirmed.
    task automatic send(input logic [15:0] v, input logic rdy, output logic [15:0] stamp);
        stamp = tb_ts;
`ifdef STABLE_FILTER_EN
        drive(v, 1'b0);
`endif
        drive(v, rdy);
    endtask

    task automatic expect_evt(input logic [15:0] v, input logic [15:0] d, input logic [15:0] t);
        exp_q.push_back({v, d, t});
    endtask

    task automatic drain(input string tag);
        logic [47:0] e;
        logic [15:0] prev_ts;
        int          n;
        prev_ts = 16'h0000;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            check_eq({tag, "_valid"}, evt_valid, 1'b1);
            check_eq({tag, "_value"}, evt_value, e[47:32]);
            check_eq({tag, "_delta"}, evt_delta, e[31:16]);
            check_eq({tag, "_ts"}, evt_timestamp, e[15:0]);
            if (i > 0) check_eq({tag, "_ts_order"}, evt_timestamp > prev_ts, 1'b1);
            prev_ts = evt_timestamp;
            evt_ready = 1'b1;
            step();
            evt_ready = 1'b0;
        end
        check_eq({tag, "_empty"}, evt_valid, 1'b0);
    endtask

    initial begin
        logic [15:0] s;
        logic [15:0] s2;
        reset        = 1'b1;
        sample_valid = 1'b0;
        evt_ready    = 1'b0;
        sample_in    = 16'h0000;

        apply_reset();
        check_eq("rst_evt_valid", evt_valid, 1'b0);
        check_eq("rst_drop", drop_count, 8'h00);
        check_eq("rst_primed", primed, 1'b0);
        check_eq("rst_value", evt_value, 16'h0000);
        check_eq("rst_delta", evt_delta, 16'h0000);
        check_eq("rst_ts", evt_timestamp, 16'h0000);

        // Test 1: 5, 5, 9 with consumer ready
        send(16'h0005, 1'b1, s);
        check_eq("t1_primed", primed, 1'b1);
        check_eq("t1_no_evt_first", evt_valid, 1'b0);
        send(16'h0005, 1'b1, s);
        check_eq("t1_no_evt_equal", evt_valid, 1'b0);
        send(16'h0009, 1'b1, s);
        expect_evt(16'h0009, 16'h0004, s);
        drain("t1");

        // Test 2: wrap-around delta
        apply_reset();
        send(16'h0001, 1'b0, s);
        check_eq("t2_primed", primed, 1'b1);
        check_eq("t2_no_evt_first", evt_valid, 1'b0);
        send(16'hFFFF, 1'b0, s);
        expect_evt(16'hFFFF, 16'hFFFE, s);
        drain("t2");

        // Test 3: consumer stalled, 7 samples with 6 changes into a 4-deep FIFO
        send(16'h0100, 1'b0, s); expect_evt(16'h0100, 16'h0101, s);
        send(16'h0200, 1'b0, s); expect_evt(16'h0200, 16'h0100, s);
        send(16'h0200, 1'b0, s);
        send(16'h0300, 1'b0, s); expect_evt(16'h0300, 16'h0100, s);
        send(16'h0400, 1'b0, s); expect_evt(16'h0400, 16'h0100, s);
        send(16'h0500, 1'b0, s);
        send(16'h0600, 1'b0, s);
        check_eq("t3_drop", drop_count, 8'd2);
        check_eq("t3_valid", evt_valid, 1'b1);
        drain("t3");

        // Test 4: full FIFO, push and pop in the same cycle
        send(16'h0700, 1'b0, s); expect_evt(16'h0700, 16'h0100, s);
        send(16'h0800, 1'b0, s); expect_evt(16'h0800, 16'h0100, s);
        send(16'h0900, 1'b0, s); expect_evt(16'h0900, 16'h0100, s);
        send(16'h0A00, 1'b0, s); expect_evt(16'h0A00, 16'h0100, s);
        check_eq("t4_drop_full", drop_count, 8'd2);
        check_eq("t4_head_first", evt_value, 16'h0700);
        send(16'h0B00, 1'b1, s);
        void'(exp_q.pop_front());
        expect_evt(16'h0B00, 16'h0100, s);
        check_eq("t4_drop_same", drop_count, 8'd2);
        check_eq("t4_head_next", evt_value, 16'h0800);
        drain("t4");

        // Test 6: reset with three events queued
        send(16'h0C00, 1'b0, s);
        send(16'h0D00, 1'b0, s);
        send(16'h0E00, 1'b0, s);
        check_eq("t6_pre_valid", evt_valid, 1'b1);
        check_eq("t6_pre_drop", drop_count, 8'd2);
        reset = 1'b1;
        step();
        check_eq("t6_valid", evt_valid, 1'b0);
        check_eq("t6_drop", drop_count, 8'd0);
        check_eq("t6_primed", primed, 1'b0);
        reset = 1'b0;
        exp_q.delete();
        send(16'h1234, 1'b0, s);
        check_eq("t6_no_evt", evt_valid, 1'b0);
        check_eq("t6_primed_again", primed, 1'b1);

        // Test 5: glitch pattern 5, 9, 5 then 5, 9, 9
        apply_reset();
`ifdef STABLE_FILTER_EN
        drive(16'h0005, 1'b0);
        drive(16'h0009, 1'b0);
        drive(16'h0005, 1'b0);
        check_eq("t5_glitch_none", evt_valid, 1'b0);
        drive(16'h0005, 1'b0);
        s = tb_ts;
        drive(16'h0009, 1'b0);
        drive(16'h0009, 1'b0);
        expect_evt(16'h0009, 16'h0004, s);
        drain("t5");
`else
        drive(16'h0005, 1'b0);
        s = tb_ts;
        drive(16'h0009, 1'b0);
        s2 = tb_ts;
        drive(16'h0005, 1'b0);
        expect_evt(16'h0009, 16'h0004, s);
        expect_evt(16'h0005, 16'hFFFC, s2);
        drain("t5");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
